// File: rtl/aes_ark_stage_if.sv
// aes_ark_stage_if: valid/ready bus of the AddRoundKey stage.
// Upstream side carries the MixColumns state plus the round key; downstream
// side carries the keyed state with its round tag. Byte i of each state
// vector sits at bits [8*i+7:8*i] (column-major: byte 4*j+r is row r, col j).
interface aes_ark_stage_if #(
  parameter int NB = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic [4*NB-1:0][7:0]    State_in;
  logic [4*NB-1:0][7:0]    Key_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NB-1:0][7:0]    State_out;
  logic [3:0]              out_round;
  logic                    out_last;
  logic                    seq_err;

  // Stage side.
  modport slave (
    input  in_valid, in_first, State_in, Key_in, out_ready,
    output in_ready, out_valid, State_out, out_round, out_last, seq_err
  );

  // Environment side (round controller upstream + capture logic downstream).
  modport master (
    output in_valid, in_first, State_in, Key_in, out_ready,
    input  in_ready, out_valid, State_out, out_round, out_last, seq_err
  );
endinterface

// File: rtl/aes_ark_stage.sv
// aes_ark_stage: registered AddRoundKey stage behind MixColumns.
// XORs state and round key before the output register, tags each beat with
// its round index (1..NR) and a final-round flag, and raises a sticky
// seq_err when a block continues without ever having been started.
// Optional build macro AES_ARK_SKID_EN: adds a one-entry skid register so
// in_ready is registered (capacity 2); otherwise a single output register
// with combinational in_ready (capacity 1).
module aes_ark_stage #(
  parameter int NB = 4,
  parameter int NR = 10
) (
  input logic            clock,
  input logic            reset,
  aes_ark_stage_if.slave bus
);

  localparam int         LP_BYTES = 4 * NB;
  localparam logic [3:0] LP_NR    = 4'(NR);

  // One beat as it travels through the buffers: data plus its round tag.
  typedef struct packed {
    logic [LP_BYTES-1:0][7:0] data;
    logic [3:0]               round;
    logic                     last;
  } beat_t;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_fire;
  logic       w_seq_err_set;
  logic [3:0] w_round;
  logic [3:0] w_rnd_next;
  beat_t      w_beat;

  logic [3:0] r_rnd;
  logic       r_seq_err;
  beat_t      r_out;
  logic       r_out_valid;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_fire   = r_out_valid & bus.out_ready;

  // Assign the incoming beat its round and build its keyed state.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_round       = 4'd1;
    w_seq_err_set = 1'b0;
    if (!bus.in_first) begin
      if (r_rnd != 4'd0) begin
        w_round = r_rnd + 4'd1;
      end else begin
        w_seq_err_set = 1'b1;
      end
    end
    w_rnd_next   = (w_round == LP_NR) ? 4'd0 : w_round;
    w_beat.data  = bus.State_in ^ bus.Key_in;
    w_beat.round = w_round;
    w_beat.last  = (w_round == LP_NR);
  end

  // Round counter and sticky sequence error, advanced once per accepted beat.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_rnd     <= 4'd0;
      r_seq_err <= 1'b0;
    end else if (w_accept) begin
      r_rnd <= w_rnd_next;
      if (w_seq_err_set) begin
        r_seq_err <= 1'b1;
      end
    end
  end

`ifdef AES_ARK_SKID_EN

  beat_t r_skid;
  logic  r_skid_valid;

  // in_ready depends only on the skid flop, never on out_ready.
  assign w_in_ready = !reset & !r_skid_valid;

  // Output register refills from skid first, then from the input; a beat
  // arriving during a stall parks in the skid register.
  always_ff @(posedge clock) begin
    // NOTE: data registers are reset too, because State_out must read zero after reset.
    if (reset) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_fire || !r_out_valid) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_beat;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_beat;
      r_skid_valid <= 1'b1;
    end
  end

`else

  // Single register: accept whenever it is empty or emptying this cycle.
  assign w_in_ready = !reset & (!r_out_valid | bus.out_ready);

  // Output register loads each accepted beat and empties on a lone fire.
  always_ff @(posedge clock) begin
    // NOTE: data registers are reset too, because State_out must read zero after reset.
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_beat;
      r_out_valid <= 1'b1;
    end else if (w_fire) begin
      r_out_valid <= 1'b0;
    end
  end

`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.State_out = r_out.data;
  assign bus.out_round = r_out.round;
  assign bus.out_last  = r_out.last;
  assign bus.seq_err   = r_seq_err;

endmodule

// File: tb/tb_aes_ark_stage.sv
// tb_aes_ark_stage: scoreboard bench for aes_ark_stage. Inputs are driven on
// the falling edge; a behavioural model of the round rules pushes expected
// beats on every accept and an independent monitor pops and compares them
// whenever the stage fires. Works with or without AES_ARK_SKID_EN.
module tb_aes_ark_stage;

  localparam int NB     = 4;
  localparam int NR     = 10;
  localparam int NBYTES = 4 * NB;
`ifdef AES_ARK_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef logic [NBYTES*8-1:0] blk_t;
  typedef struct {
    blk_t data;
    int   round;
    bit   last;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  aes_ark_stage_if #(.NB(NB)) bus ();

  aes_ark_stage #(.NB(NB), .NR(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_miss   = 0;
  int   m_rnd    = 0;   // position inside the current block, 0 = between blocks
  bit   m_err    = 1'b0;

  task automatic check(input string name, input blk_t act, input blk_t exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic blk_t rnd_blk();
    blk_t b;
    for (int i = 0; i < NBYTES / 4; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Reference model: what the spec says happens to one accepted beat.
  task automatic model_accept(input blk_t s, input blk_t k, input bit first);
    exp_t e;
    int   r;
    if (first) r = 1;
    else if (m_rnd == 0) begin
      r     = 1;
      m_err = 1'b1;
    end else r = m_rnd + 1;
    m_rnd   = (r == NR) ? 0 : r;
    e.data  = s ^ k;
    e.round = r;
    e.last  = (r == NR);
    sb.push_back(e);
  endtask

  // One cycle: drive at the falling edge, note the accept, wait for the next falling edge.
  task automatic step(input bit v, input bit first, input blk_t s, input blk_t k,
                      input bit ordy, output bit acc);
    bus.in_valid  = v;
    bus.in_first  = first;
    bus.State_in  = s;
    bus.Key_in    = k;
    bus.out_ready = ordy;
    #1;
    acc = v && bus.in_ready && !reset;
    if (acc) model_accept(s, k, first);
    @(negedge clock);
  endtask

  // Offer one random beat until taken; rand_ready randomises out_ready meanwhile.
  task automatic send(input bit first, input bit rand_ready);
    bit   acc = 1'b0;
    int   budget = 0;
    blk_t s = rnd_blk();
    blk_t k = rnd_blk();
    while (!acc && budget < 20) begin
      step(1'b1, first, s, k, rand_ready ? 1'($urandom % 2) : 1'b1, acc);
      budget++;
    end
    n_checks++;
    if (!acc) begin
      n_miss++;
      $display("FAIL send_accept: beat not taken in %0d cycles, expected acceptance", budget);
    end
  endtask

  task automatic drain(input string tag);
    bit acc;
    int budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, acc);
      budget++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain_%s: %0d beats still pending, expected 0", tag, sb.size());
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
  endtask

  // Reset for two edges, then verify the post-reset state on the first free cycle.
  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    #1 check("rst_in_ready_low", blk_t'(bus.in_ready), 0);
    @(negedge clock);
    sb.delete();
    m_rnd = 0;
    m_err = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_in_ready_high", blk_t'(bus.in_ready), 1);
    check("rst_out_valid", blk_t'(bus.out_valid), 0);
    check("rst_state_out", blk_t'(bus.State_out), 0);
    check("rst_out_round", blk_t'(bus.out_round), 0);
    check("rst_out_last", blk_t'(bus.out_last), 0);
    check("rst_seq_err", blk_t'(bus.seq_err), 0);
    @(negedge clock);
  endtask

  // Monitor: compare every fired beat with the scoreboard, and check stall stability.
  initial begin : monitor
    bit         prev_stall = 1'b0;
    blk_t       prev_data  = '0;
    logic [3:0] prev_round = '0;
    logic       prev_last  = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", blk_t'(bus.out_valid), 1);
          check("stall_data", blk_t'(bus.State_out), prev_data);
          check("stall_round", blk_t'(bus.out_round), blk_t'(prev_round));
          check("stall_last", blk_t'(bus.out_last), blk_t'(prev_last));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_miss++;
            $display("FAIL unexpected_beat: got round %0d, expected no output", bus.out_round);
          end else begin
            e = sb.pop_front();
            check("out_data", blk_t'(bus.State_out), e.data);
            check("out_round", blk_t'(bus.out_round), blk_t'(e.round));
            check("out_last", blk_t'(bus.out_last), blk_t'(e.last));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.State_out;
        prev_round = bus.out_round;
        prev_last  = bus.out_last;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit   acc;
    int   cnt;
    blk_t s;
    blk_t k;
    blk_t e;

    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.State_in  = '0;
    bus.Key_in    = '0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    do_reset();

    // Data: zero state with key bytes 0x00..0x0F, then all-0xFF state.
    for (int i = 0; i < NBYTES; i++) k[8*i +: 8] = 8'(i);
    s = '0;
    step(1'b1, 1'b1, s, k, 1'b1, acc);
    check("data_zero_state", blk_t'(bus.State_out), k);
    check("data_zero_round", blk_t'(bus.out_round), 1);
    check("data_zero_last", blk_t'(bus.out_last), 0);
    s = '1;
    for (int i = 0; i < NBYTES; i++) e[8*i +: 8] = 8'(255 - i);
    step(1'b1, 1'b1, s, k, 1'b1, acc);
    check("data_ff_state", blk_t'(bus.State_out), e);
    check("data_ff_round", blk_t'(bus.out_round), 1);
    drain("data");

    // Round sequencing: 10 back-to-back beats, then an orphan 11th.
    for (int i = 0; i < NR; i++) begin
      step(1'b1, i == 0, rnd_blk(), rnd_blk(), 1'b1, acc);
      check("seq_round", blk_t'(bus.out_round), blk_t'(i + 1));
      check("seq_last", blk_t'(bus.out_last), blk_t'(i == NR - 1));
    end
    step(1'b1, 1'b0, rnd_blk(), rnd_blk(), 1'b1, acc);
    check("orphan_round", blk_t'(bus.out_round), 1);
    drain("seq");
    check("orphan_seq_err", blk_t'(bus.seq_err), 1);
    do_reset();

    // Backpressure: out_ready low for 3 cycles with in_valid high.
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i == 0, rnd_blk(), rnd_blk(), 1'b0, acc);
      cnt += int'(acc);
    end
    check("bp_accepted", blk_t'(cnt), blk_t'(CAP));
    check("bp_in_ready", blk_t'(bus.in_ready), 0);
    drain("bp");

    // Restart on what would be round 4.
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    drain("restart");
    check("restart_seq_err", blk_t'(bus.seq_err), 0);

    // Reset with beats buffered.
    step(1'b1, 1'b1, rnd_blk(), rnd_blk(), 1'b0, acc);
    step(1'b1, 1'b0, rnd_blk(), rnd_blk(), 1'b0, acc);
    do_reset();
    step(1'b1, 1'b1, rnd_blk(), rnd_blk(), 1'b1, acc);
    check("post_reset_round", blk_t'(bus.out_round), 1);
    drain("post_reset");

    // Error stickiness across a correct block.
    do_reset();
    send(1'b0, 1'b0);
    drain("sticky_a");
    check("sticky_set", blk_t'(bus.seq_err), 1);
    for (int i = 0; i < NR; i++) send(i == 0, 1'b1);
    drain("sticky_b");
    check("sticky_hold", blk_t'(bus.seq_err), 1);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 8) == 0, rnd_blk(), rnd_blk(),
           ($urandom % 4) != 0, acc);
    end
    drain("random");
    check("random_seq_err", blk_t'(bus.seq_err), blk_t'(m_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
